aes_out_serializer: RTL
=======================

# aes_out_serializer

Downstream stage of the pipelined AES-128 core (`aes_top`). It tracks which pipeline slots carry valid blocks and captures each 128-bit `cryptokey` result as it leaves the core. Captured blocks are buffered in a small FIFO and streamed out as 32-bit words over a valid/ready interface. It also issues an input credit signal, because the core pipeline cannot stall and results must never be lost.

## Interface

- `LATENCY`, 10: rising edges from block acceptance at `aes_top` inputs to the result being sampleable on `cryptokey`; legal range 1..31.
- `FIFO_DEPTH`, 4: result blocks buffered; power of two, 2..16.
- `WORD_W`, 32: output word width; fixed to 32 in this revision, 4 words per block.

Ports (clock and reset first):

- `clk`, input, 1: single clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-low; 0 clears all state immediately.
- `in_valid`, input, 1: the upstream source is presenting `data_in`/`key` to `aes_top` this cycle.
- `in_ready`, output, 1: a credit is available; a block is accepted on an edge where `in_valid & in_ready`.
- `cryptokey`, input, 128: ciphertext output of `aes_top`.
- `out_data`, output, 32: current output word.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: downstream accepts the word on an edge where `out_valid & out_ready`.
- `out_last`, output, 1: marks the 4th (final) word of a block.
- `err_drop`, output, 1: sticky flag, set when `in_valid` is seen while `in_ready` is low.

## Operation

- **Tag pipeline:** `LATENCY`-bit shift register. Bit 0 loads `in_valid & in_ready` on each edge. When the last bit is 1, `cryptokey` is pushed into the FIFO on that same edge.
- **Credits:**
  - `inflight` = popcount of the tag register, kept as an incremental counter (+1 on accept, −1 on push).
  - `occ` = FIFO occupancy.
  - `in_ready = (inflight + occ) < FIFO_DEPTH`, combinational from registers.
  - A push can therefore never find the FIFO full. If a push does find it full, that is an assertion failure in simulation.
- **Serializer:** 2-bit word index over the FIFO head. The output order is most-significant word first:
  - word 0 = `cryptokey[127:96]`
  - word 1 = `cryptokey[95:64]`
  - word 2 = `cryptokey[63:32]`
  - word 3 = `cryptokey[31:0]`
- **Output handshake:**
  - `out_valid = ~empty`.
  - The word index increments on each handshake.
  - On the handshake of word 3, the FIFO pops and the index wraps to 0.
  - `out_last = (index == 3) & out_valid`.
- **Backpressure rules:**
  - While `out_valid & ~out_ready`, `out_data` and `out_last` hold stable.
  - `out_valid` never deasserts without a handshake.
- **Simultaneous events:**
  - Push and pop on the same edge: occupancy is unchanged, and both operations take effect.
  - Accept and push on the same edge: `inflight` is unchanged.
- **Dropped inputs:** `in_valid` while `in_ready` = 0 is not tagged. `err_drop` sets and stays set until reset.
- **Reset:**
  - Reset clears the tag register, `inflight`, FIFO pointers, word index and `err_drop`.
  - Blocks in flight or buffered are discarded; there is no partial-block output after reset.
- **Reset values of outputs:** `in_ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0, `err_drop`=0.

## Timing

- A block accepted at edge E is pushed at edge E+`LATENCY`.
- If the FIFO was empty, word 0 is visible (`out_valid`=1) in the cycle after edge E+`LATENCY`.
- With `out_ready` held at 1, the block's words hand off at edges E+`LATENCY`+1 through E+`LATENCY`+4.
- Sustained throughput is one block per 4 cycles at the output. `in_ready` therefore throttles the input to that rate once the credits are consumed.
- `in_ready` reacts on the edge after the accept or pop that changed the credit count. There is no combinational path from `in_valid` or `out_ready` to `in_ready`.

## Structure

- Shared package `aes_pkg`: `AES_BLOCK_W`=128, `AES_WORD_W`=32, `AES_WORDS_PER_BLOCK`=4, `AES_PIPE_LATENCY`=10. `aes_top` and this block both take their latency from this package.
- Sub-module `aes_sync_fifo`: parameterised width and depth; registered pointers with an extra wrap bit; outputs `empty`, `full` and `count`. The FIFO is reusable by the input-side stage.
- The top level instantiates the tag shift register, credit counter and serializer around `aes_sync_fifo`.

## Test plan

- **Single vector:** FIPS-197 input, plaintext 00112233445566778899aabbccddeeff with key 000102030405060708090a0b0c0d0e0f, `out_ready`=1 → words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, with `out_last` only on the 4th word, first word in the cycle after E+10.
- **Back-to-back:** alternate the vector above with plaintext 0123456789abcdeffedcba9876543210 and key 0f1571c947d9e8590cb7add6af7f6798, for 8 blocks → results alternate 69c4e0d8… and ff0b844a0853bf7c6934ab4364148fb9. `in_ready` throttles the input to one block per 4 cycles with no loss.
- **Backpressure:** hold `out_ready`=0 and offer continuously → exactly 4 blocks accepted, then `in_ready`=0. Release `out_ready` → 16 words in order, after which `in_ready` returns to 1.
- **Random stall:** `out_ready` toggles randomly → `out_data` is stable while stalled, word order is preserved, and no word is duplicated or skipped.
- **Drop:** `in_valid`=1 while `in_ready`=0 → `err_drop` goes to 1 and stays there; the output stream contains only the accepted blocks.
- **Reset mid-operation:** pull `reset` low with 2 blocks in flight and 1 block half-serialized → all outputs return to their reset values asynchronously. After release, a new vector produces a clean 4-word block.

Source files
------------

// File: rtl/aes_pkg.sv
// Constants shared by the AES-128 core and its surrounding stages, plus the
// block-to-word selection helper used when serializing results.
package aes_pkg;

    localparam int AES_BLOCK_W         = 128;
    localparam int AES_WORD_W          = 32;
    localparam int AES_WORDS_PER_BLOCK = AES_BLOCK_W / AES_WORD_W;
    localparam int AES_PIPE_LATENCY    = 10;

    // Word 0 is the most-significant slice of the block.
    function automatic logic [AES_WORD_W-1:0] aes_word_sel(
        input logic [AES_BLOCK_W-1:0] blk,
        input logic [1:0]             idx
    );
        logic [AES_WORD_W-1:0] w_word;
        case (idx)
            2'd0:    w_word = blk[127:96];
            2'd1:    w_word = blk[95:64];
            2'd2:    w_word = blk[63:32];
            default: w_word = blk[31:0];
        endcase
        return w_word;
    endfunction

endpackage

// File: rtl/aes_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; exposes empty/full/count.
// Storage is not reset, only the pointers are.
module aes_sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_out_serializer.sv
// Output stage of the pipelined AES-128 core: tags in-flight blocks, buffers
// results and streams them as 32-bit words under credit-based input control.
module aes_out_serializer
    import aes_pkg::*;
#(
    parameter int LATENCY    = AES_PIPE_LATENCY,
    parameter int FIFO_DEPTH = 4,
    parameter int WORD_W     = AES_WORD_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] cryptokey,
    output logic [WORD_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   err_drop
);
    localparam int         FAW      = $clog2(FIFO_DEPTH);
    localparam int         CNT_W    = FAW + 2;
    localparam logic [1:0] LAST_IDX = 2'(AES_WORDS_PER_BLOCK - 1);

    logic [LATENCY-1:0]     r_tag;
    logic [CNT_W-1:0]       r_inflight;
    logic [1:0]             r_widx;
    logic                   r_err_drop;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_hs;
    logic                   w_empty;
    logic                   w_full;
    logic [FAW:0]           w_count;
    logic [AES_BLOCK_W-1:0] w_head;
    logic [CNT_W-1:0]       w_credits_used;

    // Every accepted block owns a FIFO slot from acceptance until it is popped,
    // so a push can never meet a full FIFO.
    assign w_credits_used = r_inflight + CNT_W'(w_count);
    assign in_ready       = (w_credits_used < CNT_W'(FIFO_DEPTH));
    assign w_accept       = in_valid & in_ready;
    assign w_push         = r_tag[LATENCY-1];

    assign out_valid = ~w_empty;
    assign w_hs      = out_valid & out_ready;
    assign w_pop     = w_hs & (r_widx == LAST_IDX);
    assign out_last  = out_valid & (r_widx == LAST_IDX);
    assign out_data  = out_valid ? WORD_W'(aes_word_sel(w_head, r_widx)) : '0;
    assign err_drop  = r_err_drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tag <= '0;
        end else begin
            r_tag <= (r_tag << 1) | LATENCY'(w_accept);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inflight <= '0;
        end else begin
            case ({w_accept, w_push})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_widx <= '0;
        end else if (w_hs) begin
            r_widx <= r_widx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_drop <= 1'b0;
        end else if (in_valid & ~in_ready) begin
            r_err_drop <= 1'b1;
        end
    end

    aes_sync_fifo #(
        .WIDTH (AES_BLOCK_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_wdata (cryptokey),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    a_push_never_full: assert property (@(posedge clk) disable iff (!reset)
        !(w_push && w_full));

endmodule
